// File: rtl/alu_issue_queue.sv
// ALU issue queue: compacting, age-ordered array of decoded instructions.
// Slot 0 is the oldest entry and valid entries are always packed from slot 0.
// Each entry tracks two source tags with ready bits that are set by result-tag
// wakeup broadcasts; the oldest entry with both sources ready is presented
// to the ALU, and removing it shifts every younger entry down one slot.
module alu_issue_queue #(
    parameter int DEPTH     = 8,
    parameter int PREG_W    = 6,
    parameter int PAYLOAD_W = 96
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,

    input  logic                      dispatch_valid,
    output logic                      dispatch_ready,
    input  logic [PREG_W-1:0]         dispatch_src1_preg,
    input  logic [PREG_W-1:0]         dispatch_src2_preg,
    input  logic                      dispatch_src1_rdy,
    input  logic                      dispatch_src2_rdy,
    input  logic [PAYLOAD_W-1:0]      dispatch_payload,

    input  logic                      wake0_valid,
    input  logic [PREG_W-1:0]         wake0_preg,
    input  logic                      wake1_valid,
    input  logic [PREG_W-1:0]         wake1_preg,

    output logic                      issue_valid,
    input  logic                      alu_allowin,
    output logic [PREG_W-1:0]         issue_src1_preg,
    output logic [PREG_W-1:0]         issue_src2_preg,
    output logic [PAYLOAD_W-1:0]      issue_payload,

    output logic [$clog2(DEPTH):0]    count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Control state (reset/flush cleared)
    logic [DEPTH-1:0]      valid_q;
    logic [DEPTH-1:0]      src1_rdy_q;
    logic [DEPTH-1:0]      src2_rdy_q;
    logic [CNT_W-1:0]      count_q;

    // Data state (never reset; only meaningful under valid_q)
    logic [PREG_W-1:0]     src1_preg_q [DEPTH];
    logic [PREG_W-1:0]     src2_preg_q [DEPTH];
    logic [PAYLOAD_W-1:0]  payload_q   [DEPTH];

    // Next-state values
    logic [DEPTH-1:0]      valid_n;
    logic [DEPTH-1:0]      src1_rdy_n;
    logic [DEPTH-1:0]      src2_rdy_n;
    logic [CNT_W-1:0]      count_n;
    logic [PREG_W-1:0]     src1_preg_n [DEPTH];
    logic [PREG_W-1:0]     src2_preg_n [DEPTH];
    logic [PAYLOAD_W-1:0]  payload_n   [DEPTH];

    // Selection and handshakes
    logic [DEPTH-1:0]      entry_rdy;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_found;
    logic                  issue_fire;
    logic                  dispatch_fire;
    int                    wr_idx;

    // True when either wake port broadcasts the given tag this cycle.
    function automatic logic wake_hit(
        input logic [PREG_W-1:0] tag,
        input logic              w0_v,
        input logic [PREG_W-1:0] w0_p,
        input logic              w1_v,
        input logic [PREG_W-1:0] w1_p
    );
        return (w0_v && (w0_p == tag)) || (w1_v && (w1_p == tag));
    endfunction

    assign dispatch_ready = (count_q < CNT_W'(DEPTH));
    assign dispatch_fire  = dispatch_valid && dispatch_ready;
    assign issue_fire     = issue_valid && alu_allowin;
    assign count          = count_q;

    // Pick the oldest entry whose two sources are both available.
    always_comb begin
        entry_rdy = valid_q & src1_rdy_q & src2_rdy_q;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && entry_rdy[i]) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
    end

    // Present the selected entry to the ALU; outputs idle at zero.
    always_comb begin
        issue_valid     = |entry_rdy;
        issue_src1_preg = '0;
        issue_src2_preg = '0;
        issue_payload   = '0;
        if (issue_valid) begin
            issue_src1_preg = src1_preg_q[sel_idx];
            issue_src2_preg = src2_preg_q[sel_idx];
            issue_payload   = payload_q[sel_idx];
        end
    end

    // Build the next array: compact over the issued slot, apply wakes to the
    // entry wherever it lands, then append the dispatched instruction.
    always_comb begin
        logic             shift;
        logic [IDX_W-1:0] src;
        shift   = 1'b0;
        src     = '0;
        count_n = count_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
        wr_idx  = int'(count_q) - (issue_fire ? 1 : 0);
        for (int i = 0; i < DEPTH; i++) begin
            shift = issue_fire && (i >= int'(sel_idx));
            src   = shift ? IDX_W'(i + 1) : IDX_W'(i);

            // The top slot has nothing above it to shift in.
            valid_n[i]     = (shift && (i == DEPTH - 1)) ? 1'b0 : valid_q[src];
            src1_preg_n[i] = src1_preg_q[src];
            src2_preg_n[i] = src2_preg_q[src];
            payload_n[i]   = payload_q[src];
            src1_rdy_n[i]  = valid_n[i] &&
                             (src1_rdy_q[src] ||
                              wake_hit(src1_preg_q[src], wake0_valid, wake0_preg,
                                       wake1_valid, wake1_preg));
            src2_rdy_n[i]  = valid_n[i] &&
                             (src2_rdy_q[src] ||
                              wake_hit(src2_preg_q[src], wake0_valid, wake0_preg,
                                       wake1_valid, wake1_preg));

            if (dispatch_fire && (i == wr_idx)) begin
                valid_n[i]     = 1'b1;
                src1_preg_n[i] = dispatch_src1_preg;
                src2_preg_n[i] = dispatch_src2_preg;
                payload_n[i]   = dispatch_payload;
                src1_rdy_n[i]  = dispatch_src1_rdy ||
                                 wake_hit(dispatch_src1_preg, wake0_valid, wake0_preg,
                                          wake1_valid, wake1_preg);
                src2_rdy_n[i]  = dispatch_src2_rdy ||
                                 wake_hit(dispatch_src2_preg, wake0_valid, wake0_preg,
                                          wake1_valid, wake1_preg);
            end
        end
    end

    // Control state: reset and flush both empty the queue and win over all traffic.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q    <= '0;
            src1_rdy_q <= '0;
            src2_rdy_q <= '0;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_n;
            src1_rdy_q <= src1_rdy_n;
            src2_rdy_q <= src2_rdy_n;
            count_q    <= count_n;
        end
    end

    // Tag and payload storage follows the compaction without any reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            src1_preg_q[i] <= src1_preg_n[i];
            src2_preg_q[i] <= src2_preg_n[i];
            payload_q[i]   <= payload_n[i];
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Testbench for alu_issue_queue: directed scenarios plus randomized traffic,
// every cycle compared against a queue-based behavioural model.
module tb_alu_issue_queue;

    localparam int DEPTH     = 8;
    localparam int PREG_W    = 6;
    localparam int PAYLOAD_W = 96;

    logic                 clk = 1'b0;
    logic                 reset, flush;
    logic                 dispatch_valid, dispatch_ready;
    logic [PREG_W-1:0]    dispatch_src1_preg, dispatch_src2_preg;
    logic                 dispatch_src1_rdy, dispatch_src2_rdy;
    logic [PAYLOAD_W-1:0] dispatch_payload;
    logic                 wake0_valid, wake1_valid;
    logic [PREG_W-1:0]    wake0_preg, wake1_preg;
    logic                 issue_valid, alu_allowin;
    logic [PREG_W-1:0]    issue_src1_preg, issue_src2_preg;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [$clog2(DEPTH):0] count;

    alu_issue_queue #(.DEPTH(DEPTH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk                (clk),
        .reset              (reset),
        .flush              (flush),
        .dispatch_valid     (dispatch_valid),
        .dispatch_ready     (dispatch_ready),
        .dispatch_src1_preg (dispatch_src1_preg),
        .dispatch_src2_preg (dispatch_src2_preg),
        .dispatch_src1_rdy  (dispatch_src1_rdy),
        .dispatch_src2_rdy  (dispatch_src2_rdy),
        .dispatch_payload   (dispatch_payload),
        .wake0_valid        (wake0_valid),
        .wake0_preg         (wake0_preg),
        .wake1_valid        (wake1_valid),
        .wake1_preg         (wake1_preg),
        .issue_valid        (issue_valid),
        .alu_allowin        (alu_allowin),
        .issue_src1_preg    (issue_src1_preg),
        .issue_src2_preg    (issue_src2_preg),
        .issue_payload      (issue_payload),
        .count              (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PREG_W-1:0]    p1;
        logic [PREG_W-1:0]    p2;
        bit                   r1;
        bit                   r2;
        logic [PAYLOAD_W-1:0] pl;
    } ent_t;

    ent_t model_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit wake_match(input logic [PREG_W-1:0] t);
        return (wake0_valid && wake0_preg == t) || (wake1_valid && wake1_preg == t);
    endfunction

    task automatic idle();
        reset = 0; flush = 0; dispatch_valid = 0; alu_allowin = 0;
        dispatch_src1_preg = '0; dispatch_src2_preg = '0;
        dispatch_src1_rdy = 0; dispatch_src2_rdy = 0; dispatch_payload = '0;
        wake0_valid = 0; wake0_preg = '0; wake1_valid = 0; wake1_preg = '0;
    endtask

    task automatic set_disp(input int p1, input bit r1, input int p2, input bit r2,
                            input logic [PAYLOAD_W-1:0] pl);
        dispatch_valid     = 1;
        dispatch_src1_preg = PREG_W'(p1);
        dispatch_src1_rdy  = r1;
        dispatch_src2_preg = PREG_W'(p2);
        dispatch_src2_rdy  = r2;
        dispatch_payload   = pl;
    endtask

    // One clock: compare outputs with the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int   sel;
        bit   iv, dr, ifire, dfire;
        ent_t e;
        @(negedge clk);
        sel = -1;
        for (int i = 0; i < model_q.size(); i++)
            if (sel < 0 && model_q[i].r1 && model_q[i].r2) sel = i;
        iv = (sel >= 0);
        dr = (model_q.size() < DEPTH);
        check_val("count", 128'(count), 128'(model_q.size()));
        check_val("dispatch_ready", 128'(dispatch_ready), 128'(dr));
        check_val("issue_valid", 128'(issue_valid), 128'(iv));
        check_val("issue_payload", 128'(issue_payload), iv ? 128'(model_q[sel].pl) : 128'(0));
        check_val("issue_src1_preg", 128'(issue_src1_preg), iv ? 128'(model_q[sel].p1) : 128'(0));
        check_val("issue_src2_preg", 128'(issue_src2_preg), iv ? 128'(model_q[sel].p2) : 128'(0));
        ifire = iv && alu_allowin;
        dfire = dispatch_valid && dr;
        @(posedge clk);
        if (reset || flush) begin
            model_q.delete();
        end else begin
            if (ifire) model_q.delete(sel);
            foreach (model_q[i]) begin
                if (wake_match(model_q[i].p1)) model_q[i].r1 = 1;
                if (wake_match(model_q[i].p2)) model_q[i].r2 = 1;
            end
            if (dfire) begin
                e.p1 = dispatch_src1_preg;
                e.p2 = dispatch_src2_preg;
                e.r1 = dispatch_src1_rdy || wake_match(dispatch_src1_preg);
                e.r2 = dispatch_src2_rdy || wake_match(dispatch_src2_preg);
                e.pl = dispatch_payload;
                model_q.push_back(e);
            end
        end
        #1;
    endtask

    function automatic logic [PAYLOAD_W-1:0] rand_pl();
        return {$urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [PAYLOAD_W-1:0] pl_a, pl_b;
        logic [PAYLOAD_W-1:0] pls [3];

        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        model_q.delete();

        // Reset state
        check_val("reset_count", 128'(count), 128'(0));
        check_val("reset_dispatch_ready", 128'(dispatch_ready), 128'(1));
        check_val("reset_issue_valid", 128'(issue_valid), 128'(0));
        check_val("reset_issue_payload", 128'(issue_payload), 128'(0));

        // A waits on tag 7, younger B is ready and goes first; wake on port 1 frees A
        pl_a = 96'hA0A0_0000_0000_0000_0000_00AA;
        pl_b = 96'hB0B0_0000_0000_0000_0000_00BB;
        idle(); set_disp(5, 1, 7, 0, pl_a); cycle();
        check_val("s1_count_a", 128'(count), 128'(1));
        idle(); set_disp(1, 1, 2, 1, pl_b); cycle();
        check_val("s1_count_ab", 128'(count), 128'(2));
        check_val("s1_b_first", 128'(issue_payload), 128'(pl_b));
        idle(); alu_allowin = 1; cycle();
        check_val("s1_count_after_b", 128'(count), 128'(1));
        check_val("s1_a_blocked", 128'(issue_valid), 128'(0));
        idle(); alu_allowin = 1; wake1_valid = 1; wake1_preg = 7; cycle();
        check_val("s1_a_woken", 128'(issue_payload), 128'(pl_a));
        idle(); alu_allowin = 1; cycle();
        check_val("s1_count_empty", 128'(count), 128'(0));

        // Fill to capacity with nothing ready, then release slot 0 with a wake
        for (int i = 0; i < DEPTH; i++) begin
            idle(); set_disp(10 + i, 1, 20 + i, 0, rand_pl()); cycle();
        end
        check_val("s2_full_count", 128'(count), 128'(DEPTH));
        check_val("s2_full_ready", 128'(dispatch_ready), 128'(0));
        idle(); set_disp(3, 1, 3, 1, rand_pl()); cycle();
        check_val("s2_blocked_count", 128'(count), 128'(DEPTH));
        idle(); alu_allowin = 1; wake0_valid = 1; wake0_preg = 20; cycle();
        check_val("s2_slot0_ready", 128'(issue_src2_preg), 128'(20));
        idle(); alu_allowin = 1; cycle();
        check_val("s2_count_after", 128'(count), 128'(DEPTH - 1));
        check_val("s2_ready_after", 128'(dispatch_ready), 128'(1));
        idle(); flush = 1; cycle();
        check_val("s2_flushed", 128'(count), 128'(0));

        // Same-cycle wake catches the dispatching instruction
        idle(); set_disp(3, 1, 9, 0, rand_pl()); wake0_valid = 1; wake0_preg = 9; cycle();
        check_val("s3_wake_at_dispatch", 128'(issue_valid), 128'(1));
        idle(); alu_allowin = 1; cycle();
        check_val("s3_drained", 128'(count), 128'(0));

        // Stall with three ready entries, then drain in age order
        for (int i = 0; i < 3; i++) begin
            pls[i] = rand_pl();
            idle(); set_disp(i, 1, i + 1, 1, pls[i]); cycle();
        end
        for (int i = 0; i < 3; i++) begin
            idle(); cycle();
            check_val("s4_stall_payload", 128'(issue_payload), 128'(pls[0]));
        end
        for (int i = 0; i < 3; i++) begin
            check_val("s4_age_order", 128'(issue_payload), 128'(pls[i]));
            idle(); alu_allowin = 1; cycle();
        end
        check_val("s4_empty", 128'(issue_valid), 128'(0));

        // Flush and reset dominate simultaneous dispatch, issue and wake
        for (int i = 0; i < 4; i++) begin
            idle(); set_disp(i, 1, i, 1, rand_pl()); cycle();
        end
        check_val("s5_count4", 128'(count), 128'(4));
        idle(); set_disp(1, 1, 1, 1, rand_pl()); alu_allowin = 1; flush = 1;
        wake0_valid = 1; wake0_preg = 1; cycle();
        check_val("s5_flush_count", 128'(count), 128'(0));
        check_val("s5_flush_issue", 128'(issue_valid), 128'(0));
        for (int i = 0; i < 3; i++) begin
            idle(); set_disp(i, 1, i, 1, rand_pl()); cycle();
        end
        idle(); set_disp(2, 1, 2, 1, rand_pl()); alu_allowin = 1; reset = 1; cycle();
        check_val("s5_reset_count", 128'(count), 128'(0));
        check_val("s5_reset_issue", 128'(issue_valid), 128'(0));
        check_val("s5_reset_ready", 128'(dispatch_ready), 128'(1));

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            idle();
            reset = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 9) < 6)
                set_disp($urandom_range(0, 15), $urandom_range(0, 1) == 1,
                         $urandom_range(0, 15), $urandom_range(0, 1) == 1, rand_pl());
            alu_allowin = ($urandom_range(0, 9) < 6);
            wake0_valid = ($urandom_range(0, 9) < 4);
            wake0_preg  = PREG_W'($urandom_range(0, 15));
            wake1_valid = ($urandom_range(0, 9) < 4);
            wake1_preg  = PREG_W'($urandom_range(0, 15));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
